// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the multiplexed 7-segment scan controller.
// Contents:
//   SEG_0 .. SEG_F : active-low hex glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK      : all segments dark
//   hex_to_seg()   : nibble -> active-low glyph
//   widthOf()      : register width needed to hold values 0..n-1
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Map a hex nibble onto its active-low glyph.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] glyph;
      unique case (nibble)
         4'h0:    glyph = SEG_0;
         4'h1:    glyph = SEG_1;
         4'h2:    glyph = SEG_2;
         4'h3:    glyph = SEG_3;
         4'h4:    glyph = SEG_4;
         4'h5:    glyph = SEG_5;
         4'h6:    glyph = SEG_6;
         4'h7:    glyph = SEG_7;
         4'h8:    glyph = SEG_8;
         4'h9:    glyph = SEG_9;
         4'hA:    glyph = SEG_A;
         4'hB:    glyph = SEG_B;
         4'hC:    glyph = SEG_C;
         4'hD:    glyph = SEG_D;
         4'hE:    glyph = SEG_E;
         default: glyph = SEG_F;
      endcase
      return glyph;
   endfunction

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int widthOf(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational glyph stage that sits ahead of the output registers.
// Ports:
//   nibble_i : hex value of the digit being scanned
//   dp_i     : decimal point request, 1 = lit
//   dark_i   : force the digit dark (blanked, suppressed or PWM off)
//   seg_o    : active-low segments {g..a}
//   dp_n_o   : active-low decimal point
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       dark_i,
   output logic [6:0] seg_o,
   output logic       dp_n_o
);

   // A dark digit drives every segment and the point off regardless of data.
   always_comb begin
      seg_o  = SEG_BLANK;
      dp_n_o = 1'b1;
      if (!dark_i) begin
         seg_o  = hex_to_seg(nibble_i);
         dp_n_o = ~dp_i;
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed common-anode 7-segment controller with frame-synchronous
// shadow registers, leading-zero suppression and PWM brightness.
// Ports:
//   clk, rst    : clock; asynchronous active-low reset
//   show        : packed hex digits, digit 0 (leftmost) in the top nibble
//   dp, blank   : per-digit decimal point / blank mask, digit i at bit N-1-i
//   upd_req     : level request to load show/dp/blank at the frame boundary
//   upd_ack     : one-cycle pulse after the shadow registers were loaded
//   lz_blank    : live leading-zero suppression enable
//   duty        : live brightness, all-ones = full on, zero = dark
//   seg, dp_n   : active-low segments and decimal point
//   an          : active-low anodes, at most one low
//   frame_start : one-cycle pulse as the digit 0 slot begins
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIG_CYCLES = 10000,
   parameter int DUTY_W     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] show,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    upd_req,
   output logic                    upd_ack,
   input  logic                    lz_blank,
   input  logic [DUTY_W-1:0]       duty,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int CNT_W = widthOf(DIG_CYCLES);
   localparam int IDX_W = widthOf(NUM_DIGITS);
   localparam int STEP  = DIG_CYCLES >> DUTY_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] show_q;
   logic [NUM_DIGITS-1:0]   dp_q, blank_q;
   logic [6:0]              seg_q, seg_d;
   logic                    dpN_q, dpN_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    ack_q, ack_d;
   logic                    frameStart_q, frameStart_d;

   logic             cntWrap, boundary;
   logic [3:0]       curNibble;
   logic             curDp, curBlank, zeroRun, suppressed;
   logic [CNT_W-1:0] slot;
   logic             pwmOn, dark;

   // Slot counter and digit index; the boundary cycle is the last count of
   // the last digit, which is the only cycle where a pending update is taken.
   always_comb begin
      cntWrap  = (cnt_q == CNT_LAST);
      boundary = cntWrap && (idx_q == IDX_LAST);
      cnt_d    = cntWrap ? '0 : cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      if (cntWrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      ack_d        = boundary && upd_req;
      frameStart_d = (idx_q == '0) && (cnt_q == '0);
   end

   // Pick the scanned digit out of the shadow registers. zeroRun tracks
   // whether every digit from the left up to the current one is zero, so
   // suppression stops at the first non-zero digit; the last digit is exempt.
   always_comb begin
      curNibble  = 4'h0;
      curDp      = 1'b0;
      curBlank   = 1'b0;
      zeroRun    = 1'b1;
      suppressed = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (show_q[4*(NUM_DIGITS-1-i) +: 4] != 4'h0) begin
            zeroRun = 1'b0;
         end
         if (IDX_W'(i) == idx_q) begin
            curNibble  = show_q[4*(NUM_DIGITS-1-i) +: 4];
            curDp      = dp_q[NUM_DIGITS-1-i];
            curBlank   = blank_q[NUM_DIGITS-1-i];
            suppressed = lz_blank && (i < NUM_DIGITS-1) && zeroRun;
         end
      end
   end

   // Each digit slot is cut into 2**DUTY_W equal PWM steps; the anode is on
   // for the first 'duty' steps, and all-ones means the whole slot.
   always_comb begin
      slot  = cnt_q / CNT_W'(STEP);
      pwmOn = (duty == '1) || (slot < CNT_W'(duty));
      dark  = curBlank || suppressed || !pwmOn;
      an_d  = '1;
      if (!dark) begin
         an_d = ~(NUM_DIGITS'(1) << (IDX_LAST - idx_q));
      end
   end

   seg7_decode u_decode (
      .nibble_i (curNibble),
      .dp_i     (curDp),
      .dark_i   (dark),
      .seg_o    (seg_d),
      .dp_n_o   (dpN_d)
   );

   // Counters and registered outputs; everything visible reflects the
   // previous cycle's scan position.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         seg_q        <= SEG_BLANK;
         dpN_q        <= 1'b1;
         an_q         <= '1;
         ack_q        <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         seg_q        <= seg_d;
         dpN_q        <= dpN_d;
         an_q         <= an_d;
         ack_q        <= ack_d;
         frameStart_q <= frameStart_d;
      end
   end

   // Shadow registers only change on the frame boundary, so a frame is never
   // shown with a mix of old and new data. They reset to fully blanked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         show_q  <= '0;
         dp_q    <= '0;
         blank_q <= '1;
      end else if (ack_d) begin
         show_q  <= show;
         dp_q    <= dp;
         blank_q <= blank;
      end
   end

   assign seg         = seg_q;
   assign dp_n        = dpN_q;
   assign an          = an_q;
   assign upd_ack     = ack_q;
   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl (4 digits, 16 cycles per digit, 2-bit
// duty). A position-based model predicts every output each cycle; directed
// frames below pin the model with literal glyph/anode values.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DC    = 16;
   localparam int DW    = 2;
   localparam int FRAME = N * DC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] show = 16'h0;
   logic [3:0]  dp = 4'h0;
   logic [3:0]  blank = 4'h0;
   logic        updReq = 1'b0;
   logic        lzBlank = 1'b0;
   logic [1:0]  duty = 2'd3;
   logic        updAck;
   logic [6:0]  seg;
   logic        dpN;
   logic [3:0]  an;
   logic        frameStart;

   int compared = 0;
   int mismatched = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(N), .DIG_CYCLES(DC), .DUTY_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .show        (show),
      .dp          (dp),
      .blank       (blank),
      .upd_req     (updReq),
      .upd_ack     (updAck),
      .lz_blank    (lzBlank),
      .duty        (duty),
      .seg         (seg),
      .dp_n        (dpN),
      .an          (an),
      .frame_start (frameStart)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Glyph table written straight from the seven-segment layout.
   logic [6:0] glyph [16];
   initial begin
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
   end

   // Model: mPos is the number of clock edges since reset release. The output
   // seen after an edge belongs to the position held just before that edge.
   int          mPos = 0;
   logic [15:0] mShow = 16'h0;
   logic [3:0]  mDp = 4'h0;
   logic [3:0]  mBlank = 4'hF;
   int          digit, c;
   logic        allZero, sup, lit;
   logic [3:0]  nib, eAn;
   logic [6:0]  eSeg;
   logic        eDp, eAck, eFs;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mPos   = 0;
         mShow  = 16'h0;
         mDp    = 4'h0;
         mBlank = 4'hF;
         #1;
         checkOutput("model_rst_an", an, 4'hF);
         checkOutput("model_rst_seg", seg, 7'h7F);
         checkOutput("model_rst_dpn", dpN, 1'b1);
         checkOutput("model_rst_ack", updAck, 1'b0);
         checkOutput("model_rst_fs", frameStart, 1'b0);
      end else begin
         digit   = (mPos / DC) % N;
         c       = mPos % DC;
         nib     = 4'((mShow >> (4 * (N - 1 - digit))) & 16'hF);
         allZero = 1'b1;
         for (int i = 0; i <= digit; i++) begin
            if (((mShow >> (4 * (N - 1 - i))) & 16'hF) != 16'h0) allZero = 1'b0;
         end
         sup  = lzBlank && (digit < N - 1) && allZero;
         lit  = !mBlank[N-1-digit] && !sup && ((duty == 2'b11) || (c < int'(duty) * (DC / 4)));
         eAn  = lit ? ~(4'b1000 >> digit) : 4'hF;
         eSeg = lit ? glyph[nib] : 7'h7F;
         eDp  = lit ? !mDp[N-1-digit] : 1'b1;
         eFs  = (mPos % FRAME) == 0;
         eAck = ((mPos % FRAME) == FRAME - 1) && updReq;
         if (eAck) begin
            mShow  = show;
            mDp    = dp;
            mBlank = blank;
         end
         mPos++;
         #1;
         checkOutput("model_an", an, eAn);
         checkOutput("model_seg", seg, eSeg);
         checkOutput("model_dpn", dpN, eDp);
         checkOutput("model_ack", updAck, eAck);
         checkOutput("model_fs", frameStart, eFs);
      end
   end

   // Request an update and hold it until the acknowledge is seen.
   task automatic applyStimulus(input logic [15:0] s, input logic [3:0] d, input logic [3:0] b);
      show   = s;
      dp     = d;
      blank  = b;
      updReq = 1'b1;
      for (int k = 0; k < FRAME + 4; k++) begin
         @(negedge clk);
         if (updAck) break;
      end
      checkOutput("ack_seen", updAck, 1'b1);
      updReq = 1'b0;
   endtask

   // Advance to the first cycle where frame_start is visible.
   task automatic syncFrame();
      for (int k = 0; k < FRAME + 4; k++) begin
         @(negedge clk);
         if (frameStart) break;
      end
      checkOutput("frame_start_found", frameStart, 1'b1);
   endtask

   // Check one full frame against literal per-digit values (digit 0 in the
   // top field of each packed argument); also expects no ack inside it.
   task automatic checkFrame(input string name, input logic [15:0] anAll,
                             input logic [27:0] segAll, input logic [3:0] dpnAll);
      int ackCount;
      ackCount = 0;
      for (int d = 0; d < N; d++) begin
         for (int k = 0; k < DC; k++) begin
            checkOutput($sformatf("%s_d%0d_an", name, d), an, anAll[15-4*d -: 4]);
            checkOutput($sformatf("%s_d%0d_seg", name, d), seg, segAll[27-7*d -: 7]);
            checkOutput($sformatf("%s_d%0d_dpn", name, d), dpN, dpnAll[3-d]);
            if (updAck) ackCount++;
            @(negedge clk);
         end
      end
      checkOutput($sformatf("%s_no_ack", name), ackCount, 0);
   endtask

   localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   initial begin
      int fsCount, litCount, ackCount, waited;
      int lowCnt [4];
      logic [1:0] dutyList [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      int expLow [4] = '{4, 8, 16, 0};

      // Reset held across a few edges.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_an", an, 4'hF);
      checkOutput("reset_seg", seg, 7'h7F);
      checkOutput("reset_dpn", dpN, 1'b1);
      checkOutput("reset_ack", updAck, 1'b0);
      checkOutput("reset_fs", frameStart, 1'b0);
      rst = 1'b1;

      // Idle: dark display, frame_start every 64 cycles (edges 1, 65, 129, 193).
      fsCount  = 0;
      litCount = 0;
      repeat (200) begin
         @(negedge clk);
         if (frameStart) fsCount++;
         if (an != 4'hF || seg != 7'h7F || dpN != 1'b1) litCount++;
      end
      checkOutput("idle_frame_starts", fsCount, 4);
      checkOutput("idle_lit_cycles", litCount, 0);

      // Basic hex display with a decimal point on digit 2.
      applyStimulus(16'h12AF, 4'b0010, 4'b0000);
      syncFrame();
      checkFrame("hex12AF", AN_ALL, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1101);

      // Leading-zero suppression.
      lzBlank = 1'b1;
      applyStimulus(16'h0005, 4'b0000, 4'b0000);
      syncFrame();
      checkFrame("lz0005", {4'hF, 4'hF, 4'hF, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'hF);
      applyStimulus(16'h0000, 4'b0000, 4'b0000);
      syncFrame();
      checkFrame("lz0000", {4'hF, 4'hF, 4'hF, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF);
      applyStimulus(16'h0105, 4'b0000, 4'b0000);
      syncFrame();
      checkFrame("lz0105", {4'hF, 4'b1011, 4'b1101, 4'b1110},
                 {7'h7F, 7'b1111001, 7'b1000000, 7'b0010010}, 4'hF);
      lzBlank = 1'b0;

      // Duty sweep: count low cycles per anode over one frame.
      applyStimulus(16'h12AF, 4'b0010, 4'b0000);
      for (int j = 0; j < 4; j++) begin
         duty = dutyList[j];
         syncFrame();
         for (int i = 0; i < N; i++) lowCnt[i] = 0;
         for (int s = 0; s < FRAME; s++) begin
            for (int i = 0; i < N; i++) if (!an[N-1-i]) lowCnt[i]++;
            @(negedge clk);
         end
         for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("duty%0d_digit%0d_low", dutyList[j], i), lowCnt[i], expLow[j]);
         end
      end
      duty = 2'd3;

      // Data change without a request has no visible effect.
      show = 16'h3456;
      syncFrame();
      checkFrame("noreq", AN_ALL, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1101);

      // Request raised at frame cycle 20; ack one cycle after cycle 63.
      repeat (19) @(negedge clk);
      updReq = 1'b1;
      waited = 0;
      for (int k = 0; k < FRAME + 4; k++) begin
         @(negedge clk);
         waited++;
         if (updAck) break;
      end
      checkOutput("ack_latency", waited, 44);
      checkOutput("last_old_glyph", seg, 7'b0001110);
      updReq = 1'b0;
      syncFrame();
      checkFrame("upd3456", AN_ALL, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}, 4'b1101);

      // Asynchronous reset mid-frame with a request pending.
      updReq = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_an", an, 4'hF);
      checkOutput("async_rst_seg", seg, 7'h7F);
      checkOutput("async_rst_dpn", dpN, 1'b1);
      checkOutput("async_rst_ack", updAck, 1'b0);
      checkOutput("async_rst_fs", frameStart, 1'b0);
      @(negedge clk);
      updReq = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ackCount = 0;
      litCount = 0;
      repeat (150) begin
         @(negedge clk);
         if (updAck) ackCount++;
         if (an != 4'hF) litCount++;
      end
      checkOutput("post_rst_no_ack", ackCount, 0);
      checkOutput("post_rst_dark", litCount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
